// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit bus adapter: mem_op encodings,
// FSM state encoding, strobe width and the request legality check.
package lsu_pkg;

   localparam int STRB_W = 4;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Misaligned halfword/word, reserved funct3, or unsigned op used as a store.
   function automatic logic req_bad(input logic we, input logic [2:0] op,
                                    input logic [1:0] addr_lo);
      logic bad;
      case (op)
         OP_B:    bad = 1'b0;
         OP_H:    bad = addr_lo[0];
         OP_W:    bad = (addr_lo != 2'b00);
         OP_BU:   bad = we;
         OP_HU:   bad = we | addr_lo[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe and data replication, load lane
// extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]        i_op,
   input  logic [1:0]        i_addr_lo,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [WIDTH-1:0]  i_rword,
   output logic [STRB_W-1:0] o_wstrb,
   output logic [WIDTH-1:0]  o_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

   // Byte lane select for loads.
   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rword[7:0];
         2'd1:    w_byte = i_rword[15:8];
         2'd2:    w_byte = i_rword[23:16];
         default: w_byte = i_rword[31:24];
      endcase
   end

   // Store strobes and lane replication.
   always_comb begin
      case (i_op)
         OP_B: begin
            o_wstrb = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         OP_H: begin
            o_wstrb = 4'b0011 << i_addr_lo;
            o_wdata = {2{i_wdata[15:0]}};
         end
         OP_W: begin
            o_wstrb = 4'b1111;
            o_wdata = i_wdata;
         end
         default: begin
            o_wstrb = 4'b0000;
            o_wdata = i_wdata;
         end
      endcase
   end

   // Load extension.
   always_comb begin
      case (i_op)
         OP_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
         OP_BU:   o_rdata = {24'd0, w_byte};
         OP_H:    o_rdata = {{16{w_half[15]}}, w_half};
         OP_HU:   o_rdata = {16'd0, w_half};
         OP_W:    o_rdata = i_rword;
         default: o_rdata = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit to single-outstanding memory bus adapter: request latch,
// IDLE/BUS/WAIT/DONE sequencing and registered bus/response outputs.
module lsu_bus
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_op,
   input  logic [WIDTH-1:0]  req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  resp_rdata,
   output logic              resp_err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [WIDTH-1:0]  bus_addr,
   output logic [WIDTH-1:0]  bus_wdata,
   output logic [STRB_W-1:0] bus_wstrb,
   input  logic              bus_rsp_valid,
   input  logic [WIDTH-1:0]  bus_rsp_rdata,
   input  logic              bus_rsp_err
);

   logic [1:0]        r_state;
   logic              r_we;
   logic [2:0]        r_op;
   logic [1:0]        r_addr_lo;
   logic              r_req_ready;
   logic              r_bus_req_valid;
   logic              r_bus_we;
   logic [WIDTH-1:0]  r_bus_addr;
   logic [WIDTH-1:0]  r_bus_wdata;
   logic [STRB_W-1:0] r_bus_wstrb;
   logic              r_resp_valid;
   logic [WIDTH-1:0]  r_resp_rdata;
   logic              r_resp_err;

   logic              w_accept;
   logic              w_bad;
   logic [2:0]        w_op;
   logic [1:0]        w_addr_lo;
   logic [STRB_W-1:0] w_strb;
   logic [WIDTH-1:0]  w_wdata;
   logic [WIDTH-1:0]  w_rdata;

   // r_req_ready is only ever set while in IDLE, so it doubles as the state qualifier.
   assign w_accept  = req_valid & r_req_ready;
   assign w_bad     = req_bad(req_we, req_op, req_addr[1:0]);
   assign w_op      = (r_state == ST_IDLE) ? req_op : r_op;
   assign w_addr_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .i_op      (w_op),
      .i_addr_lo (w_addr_lo),
      .i_wdata   (req_wdata),
      .i_rword   (bus_rsp_rdata),
      .o_wstrb   (w_strb),
      .o_wdata   (w_wdata),
      .o_rdata   (w_rdata)
   );

   // Transaction FSM and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= ST_IDLE;
         r_we            <= 1'b0;
         r_op            <= 3'b000;
         r_addr_lo       <= 2'b00;
         r_req_ready     <= 1'b0;
         r_bus_req_valid <= 1'b0;
         r_bus_we        <= 1'b0;
         r_bus_addr      <= {WIDTH{1'b0}};
         r_bus_wdata     <= {WIDTH{1'b0}};
         r_bus_wstrb     <= {STRB_W{1'b0}};
         r_resp_valid    <= 1'b0;
         r_resp_rdata    <= {WIDTH{1'b0}};
         r_resp_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_we        <= req_we;
                  r_op        <= req_op;
                  r_addr_lo   <= req_addr[1:0];
                  if (w_bad) begin
                     r_state      <= ST_DONE;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= {WIDTH{1'b0}};
                  end else begin
                     r_state         <= ST_BUS;
                     r_bus_req_valid <= 1'b1;
                     r_bus_we        <= req_we;
                     r_bus_addr      <= {req_addr[WIDTH-1:2], 2'b00};
                     r_bus_wstrb     <= req_we ? w_strb : {STRB_W{1'b0}};
                     r_bus_wdata     <= req_we ? w_wdata : {WIDTH{1'b0}};
                  end
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            ST_BUS: begin
               if (bus_req_ready) begin
                  r_state         <= ST_WAIT;
                  r_bus_req_valid <= 1'b0;
                  r_bus_we        <= 1'b0;
                  r_bus_addr      <= {WIDTH{1'b0}};
                  r_bus_wdata     <= {WIDTH{1'b0}};
                  r_bus_wstrb     <= {STRB_W{1'b0}};
               end
            end
            ST_WAIT: begin
               if (bus_rsp_valid) begin
                  r_state      <= ST_DONE;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= bus_rsp_err;
                  r_resp_rdata <= (r_we | bus_rsp_err) ? {WIDTH{1'b0}} : w_rdata;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= {WIDTH{1'b0}};
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign bus_req_valid = r_bus_req_valid;
   assign bus_we        = r_bus_we;
   assign bus_addr      = r_bus_addr;
   assign bus_wdata     = r_bus_wdata;
   assign bus_wstrb     = r_bus_wstrb;
   assign resp_valid    = r_resp_valid;
   assign resp_rdata    = r_resp_rdata;
   assign resp_err      = r_resp_err;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed self-checking bench for lsu_bus; outputs sampled 1ns after the rising edge.
module tb_lsu_bus;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_rsp_valid, bus_rsp_err;
   logic [31:0] bus_rsp_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_bus #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_op        (req_op),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_wstrb     (bus_wstrb),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata),
      .bus_rsp_err   (bus_rsp_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one request and returns just after the accept edge (T+1 window).
   task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic load_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
      issue(1'b0, op, addr, 32'd0);
      chk({tag, "_busv"}, 32'(bus_req_valid), 32'd1);
      tick();
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = word;
      tick();
      bus_rsp_valid = 1'b0;
      chk({tag, "_respv"}, 32'(resp_valid), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, exp);
      chk({tag, "_err"}, 32'(resp_err), 32'd0);
      tick();
      chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst           = 1'b0;
      req_valid     = 1'b0;
      req_we        = 1'b0;
      req_op        = 3'b000;
      req_addr      = 32'd0;
      req_wdata     = 32'd0;
      resp_ready    = 1'b1;
      bus_req_ready = 1'b1;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = 32'd0;
      bus_rsp_err   = 1'b0;

      repeat (2) tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      rst = 1'b1;
      tick();
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      // lw 0x80000004 with latency checks at every step
      issue(1'b0, 3'b010, 32'h8000_0004, 32'd0);
      chk("lw_T1_busv", 32'(bus_req_valid), 32'd1);
      chk("lw_T1_addr", bus_addr, 32'h8000_0004);
      chk("lw_T1_wstrb", 32'(bus_wstrb), 32'd0);
      chk("lw_T1_we", 32'(bus_we), 32'd0);
      chk("lw_T1_rdy", 32'(req_ready), 32'd0);
      tick();
      chk("lw_T2_busv", 32'(bus_req_valid), 32'd0);
      chk("lw_T2_respv", 32'(resp_valid), 32'd0);
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 32'hDEAD_BEEF;
      tick();
      bus_rsp_valid = 1'b0;
      chk("lw_T3_respv", 32'(resp_valid), 32'd1);
      chk("lw_T3_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("lw_T3_err", 32'(resp_err), 32'd0);
      chk("lw_T3_rdy", 32'(req_ready), 32'd0);
      tick();
      chk("lw_T4_rdy", 32'(req_ready), 32'd1);
      chk("lw_T4_respv", 32'(resp_valid), 32'd0);

      load_txn("lb", 3'b000, 32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80);
      load_txn("lbu", 3'b100, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080);
      load_txn("lhu", 3'b101, 32'h8000_0002, 32'h80FF_0000, 32'h0000_80FF);
      load_txn("lh_lo", 3'b001, 32'h8000_0000, 32'h1234_9ABC, 32'hFFFF_9ABC);

      // sh at byte 2: upper two lanes, halfword replicated
      issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD);
      chk("sh_busv", 32'(bus_req_valid), 32'd1);
      chk("sh_we", 32'(bus_we), 32'd1);
      chk("sh_wstrb", 32'(bus_wstrb), 32'h0000_000C);
      chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
      chk("sh_addr", bus_addr, 32'h8000_0000);
      tick();
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 32'h5555_5555;
      tick();
      bus_rsp_valid = 1'b0;
      chk("sh_respv", 32'(resp_valid), 32'd1);
      chk("sh_rdata", resp_rdata, 32'd0);
      tick();

      // misaligned lw: no bus cycle, error response right after accept
      issue(1'b0, 3'b010, 32'h8000_0001, 32'd0);
      chk("mis_busv", 32'(bus_req_valid), 32'd0);
      chk("mis_respv", 32'(resp_valid), 32'd1);
      chk("mis_err", 32'(resp_err), 32'd1);
      chk("mis_rdata", resp_rdata, 32'd0);
      tick();
      chk("mis_rdy", 32'(req_ready), 32'd1);
      chk("mis_busv2", 32'(bus_req_valid), 32'd0);

      // store with unsigned op is illegal
      issue(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("ill_busv", 32'(bus_req_valid), 32'd0);
      chk("ill_err", 32'(resp_err), 32'd1);
      tick();

      // sb at byte 3 with bus stalled 3 cycles, then bus error
      bus_req_ready = 1'b0;
      issue(1'b1, 3'b000, 32'h8000_0013, 32'h0000_0077);
      for (int i = 0; i < 3; i++) begin
         chk("stall_busv", 32'(bus_req_valid), 32'd1);
         chk("stall_addr", bus_addr, 32'h8000_0010);
         chk("stall_wstrb", 32'(bus_wstrb), 32'h0000_0008);
         chk("stall_wdata", bus_wdata, 32'h7777_7777);
         tick();
      end
      chk("stall_busv_end", 32'(bus_req_valid), 32'd1);
      bus_req_ready = 1'b1;
      tick();
      chk("stall_busv_drop", 32'(bus_req_valid), 32'd0);
      bus_rsp_valid = 1'b1;
      bus_rsp_err   = 1'b1;
      tick();
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      chk("berr_respv", 32'(resp_valid), 32'd1);
      chk("berr_err", 32'(resp_err), 32'd1);
      chk("berr_rdata", resp_rdata, 32'd0);
      tick();

      // lh upper half with WB stalled 2 cycles
      resp_ready = 1'b0;
      issue(1'b0, 3'b001, 32'h8000_0002, 32'd0);
      tick();
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 32'hC001_1234;
      tick();
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         chk("wbstall_respv", 32'(resp_valid), 32'd1);
         chk("wbstall_rdata", resp_rdata, 32'hFFFF_C001);
         chk("wbstall_rdy", 32'(req_ready), 32'd0);
         if (i < 2) tick();
      end
      resp_ready = 1'b1;
      tick();
      chk("wbstall_respv_end", 32'(resp_valid), 32'd0);
      chk("wbstall_rdy_end", 32'(req_ready), 32'd1);

      // reset while waiting for the bus response
      issue(1'b0, 3'b010, 32'h8000_0008, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_rdy", 32'(req_ready), 32'd0);
      chk("midrst_busv", 32'(bus_req_valid), 32'd0);
      chk("midrst_respv", 32'(resp_valid), 32'd0);
      chk("midrst_rdata", resp_rdata, 32'd0);
      chk("midrst_err", 32'(resp_err), 32'd0);
      rst           = 1'b1;
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 32'h1111_2222;
      tick();
      tick();
      bus_rsp_valid = 1'b0;
      chk("stale_respv", 32'(resp_valid), 32'd0);
      chk("stale_rdy", 32'(req_ready), 32'd1);
      chk("stale_busv", 32'(bus_req_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
